// File: rtl/uart_rx.sv
// uart_rx: UART serial receiver; 8N1 / 8E1 / 8O1 frames, LSB first, mid-bit sampling.
// Ports: clk, rst (sync, active high), rx_in (async serial line), parity_en, parity_type
//        (0 even, 1 odd), data, data_valid (1-cycle strobe), parity_error, stop_error, busy.
module uart_rx #(
    parameter int CLKS_PER_BIT = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_in,
    input  logic       parity_en,
    input  logic       parity_type,
    output logic [7:0] data,
    output logic       data_valid,
    output logic       parity_error,
    output logic       stop_error,
    output logic       busy
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        WAIT_HIGH
    } state_t;

    state_t        state;
    logic          sync1;
    logic          rx_s;
    logic [CW-1:0] clk_cnt;
    logic [2:0]    bit_cnt;
    logic [7:0]    shreg;
    logic          par_en_l;
    logic          par_type_l;
    logic          par_err;

    // Two-flop synchronizer; idles high so reset never looks like a start bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b1;
            rx_s  <= 1'b1;
        end else begin
            sync1 <= rx_in;
            rx_s  <= sync1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            clk_cnt      <= '0;
            bit_cnt      <= '0;
            shreg        <= '0;
            par_en_l     <= 1'b0;
            par_type_l   <= 1'b0;
            par_err      <= 1'b0;
            data         <= '0;
            data_valid   <= 1'b0;
            parity_error <= 1'b0;
            stop_error   <= 1'b0;
            busy         <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    clk_cnt <= '0;
                    if (!rx_s) begin
                        state      <= START;
                        busy       <= 1'b1;
                        par_en_l   <= parity_en;
                        par_type_l <= parity_type;
                        par_err    <= 1'b0;
                    end
                end
                START: begin
                    // Half a bit in: still low means a real start bit.
                    if (clk_cnt == HALF_M1) begin
                        clk_cnt <= '0;
                        if (rx_s) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            state   <= DATA;
                            bit_cnt <= '0;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + CW'(1);
                    end
                end
                DATA: begin
                    if (clk_cnt == FULL_M1) begin
                        clk_cnt        <= '0;
                        shreg[bit_cnt] <= rx_s;
                        if (bit_cnt == 3'd7) begin
                            state <= par_en_l ? PARITY : STOP;
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + CW'(1);
                    end
                end
                PARITY: begin
                    if (clk_cnt == FULL_M1) begin
                        clk_cnt <= '0;
                        // Expected bit is ^data (even) or its inverse (odd).
                        par_err <= rx_s ^ (^shreg) ^ par_type_l;
                        state   <= STOP;
                    end else begin
                        clk_cnt <= clk_cnt + CW'(1);
                    end
                end
                STOP: begin
                    if (clk_cnt == FULL_M1) begin
                        clk_cnt      <= '0;
                        data         <= shreg;
                        parity_error <= par_err;
                        stop_error   <= ~rx_s;
                        data_valid   <= 1'b1;
                        if (rx_s) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            state <= WAIT_HIGH;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + CW'(1);
                    end
                end
                WAIT_HIGH: begin
                    // A held-low (break) line must not be re-read as a start bit.
                    if (rx_s) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: self-checking bench for uart_rx (CLKS_PER_BIT = 8).
// Vector table plus hand sequences; strobes are checked against a scoreboard queue.
module tb_uart_rx;

    localparam int C = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx_in;
    logic       parity_en;
    logic       parity_type;
    logic [7:0] data;
    logic       data_valid;
    logic       parity_error;
    logic       stop_error;
    logic       busy;

    int cyc    = 0;
    int total  = 0;
    int passed = 0;

    typedef struct {
        logic [7:0] d;
        logic       pe;
        logic       se;
        int         cyc;
    } exp_t;

    typedef struct {
        logic [7:0] b;
        logic       pen;
        logic       ptype;
        logic       pbit;
        logic       stopb;
        logic       perr;
        logic       serr;
    } vec_t;

    exp_t q[$];
    vec_t vecs[7];

    uart_rx #(.CLKS_PER_BIT(C)) dut (
        .clk(clk),
        .rst(rst),
        .rx_in(rx_in),
        .parity_en(parity_en),
        .parity_type(parity_type),
        .data(data),
        .data_valid(data_valid),
        .parity_error(parity_error),
        .stop_error(stop_error),
        .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     name, act, exp, cyc);
        end else begin
            passed++;
        end
    endtask

    // Scoreboard: every strobe must match the oldest pushed frame.
    always @(negedge clk) begin
        if (data_valid) begin
            check("strobe_expected", 32'(q.size() != 0), 32'd1);
            if (q.size() != 0) begin
                exp_t e;
                e = q.pop_front();
                check("data", 32'(data), 32'(e.d));
                check("parity_error", 32'(parity_error), 32'(e.pe));
                check("stop_error", 32'(stop_error), 32'(e.se));
                check("strobe_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    task automatic drive_bit(input logic v);
        rx_in = v;
        repeat (C) @(negedge clk);
    endtask

    // Called at a negedge; the start bit falls on that negedge.
    task automatic send(input logic [7:0] b, input logic pen,
                        input logic ptype, input logic pbit,
                        input logic stopb, input logic want,
                        input logic ep, input logic es);
        exp_t e;
        parity_en   = pen;
        parity_type = ptype;
        if (want) begin
            e.d   = b;
            e.pe  = ep;
            e.se  = es;
            e.cyc = cyc + (pen ? 87 : 79);
            q.push_back(e);
        end
        drive_bit(1'b0);
        // Settings are latched at frame start; scrambling them must not matter.
        parity_en   = ~pen;
        parity_type = ~ptype;
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        if (pen) drive_bit(pbit);
        drive_bit(stopb);
    endtask

    initial begin
        logic seen;

        vecs[0] = '{8'h4B, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{8'h4B, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{8'h4B, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[3] = '{8'hA5, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[4] = '{8'h3C, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[5] = '{8'hFF, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[6] = '{8'h01, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};

        rst         = 1'b1;
        rx_in       = 1'b1;
        parity_en   = 1'b0;
        parity_type = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_data", 32'(data), 32'h0);
        check("rst_valid", 32'(data_valid), 32'h0);
        check("rst_perr", 32'(parity_error), 32'h0);
        check("rst_serr", 32'(stop_error), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            send(vecs[i].b, vecs[i].pen, vecs[i].ptype, vecs[i].pbit,
                 vecs[i].stopb, 1'b1, vecs[i].perr, vecs[i].serr);
            drive_bit(1'b1);
            drive_bit(1'b1);
            check("idle_busy", 32'(busy), 32'h0);
            check("data_hold", 32'(data), 32'(vecs[i].b));
        end

        // Back-to-back, no idle gap, parity disabled.
        send(8'h4B, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        send(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        send(8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        drive_bit(1'b1);
        check("b2b_drained", 32'(q.size()), 32'h0);

        // Framing error followed by a held-low break.
        send(8'h4B, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        rx_in = 1'b0;
        repeat (40) @(negedge clk);
        check("break_busy", 32'(busy), 32'h1);
        check("break_strobed", 32'(q.size()), 32'h0);
        rx_in = 1'b1;
        repeat (5) @(negedge clk);
        check("break_release_busy", 32'(busy), 32'h0);
        drive_bit(1'b1);

        // Short glitch is a false start.
        rx_in = 1'b0;
        repeat (3) @(negedge clk);
        rx_in = 1'b1;
        seen  = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (busy) seen = 1'b1;
        end
        check("glitch_busy_seen", 32'(seen), 32'h1);
        check("glitch_busy_end", 32'(busy), 32'h0);
        send(8'h3C, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        drive_bit(1'b1);

        // Reset in the middle of data bit 4; frame 0xF0 must not be reported.
        parity_en   = 1'b0;
        parity_type = 1'b0;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(1'b0);
        rx_in = 1'b1;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_data", 32'(data), 32'h0);
        check("mid_rst_valid", 32'(data_valid), 32'h0);
        check("mid_rst_perr", 32'(parity_error), 32'h0);
        check("mid_rst_serr", 32'(stop_error), 32'h0);
        check("mid_rst_busy", 32'(busy), 32'h0);
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) drive_bit(1'b1);
        drive_bit(1'b1);
        drive_bit(1'b1);
        send(8'h81, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);

        repeat (20) @(negedge clk);
        check("pending_frames", 32'(q.size()), 32'h0);
        check("final_busy", 32'(busy), 32'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
